// File: rtl/bpu_resolve_ctrl.sv
// Branch resolution controller: tracks in-flight predictions, trains the bpu on every
// resolve and redirects fetch with a full queue flush on a mispredict.
module bpu_resolve_ctrl #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_pred_valid,
    input  logic [N-1:0]             i_pred_pc,
    input  logic                     i_pred_taken,
    input  logic [N-1:0]             i_pred_target,
    output logic                     o_pred_ready,
    input  logic                     i_res_valid,
    input  logic                     i_res_taken,
    input  logic [N-1:0]             i_res_target,
    output logic                     o_upd_valid,
    output logic [N-1:0]             o_upd_pc,
    output logic                     o_upd_taken,
    output logic                     o_redirect,
    output logic [N-1:0]             o_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_inflight,
    output logic [CNT_W-1:0]         o_mispredict_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef logic [PtrW:0] ptr_t;
    typedef enum logic {StRun, StRecover} state_e;

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;

    logic [N-1:0] pc_mem    [DEPTH];
    logic         taken_mem [DEPTH];
    logic [N-1:0] tgt_mem   [DEPTH];

    logic             upd_valid_q, upd_taken_q, redirect_q;
    logic [N-1:0]     upd_pc_q, redirect_pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic         full, empty, push, pop, mispredict;
    logic [N-1:0] e_pc, e_target;
    logic         e_taken;

    // Pointers carry a wrap bit: equal low bits with differing wrap bits means full.
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign o_pred_ready = (state_q == StRun) && !full;
    assign push         = i_pred_valid && o_pred_ready;
    assign pop          = i_res_valid && !empty && (state_q == StRun);

    assign e_pc     = pc_mem[rd_ptr_q[PtrW-1:0]];
    assign e_taken  = taken_mem[rd_ptr_q[PtrW-1:0]];
    assign e_target = tgt_mem[rd_ptr_q[PtrW-1:0]];

    assign mispredict = pop && ((e_taken != i_res_taken) ||
                                (i_res_taken && (e_target != i_res_target)));

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q[PtrW-1:0]]    <= i_pred_pc;
            taken_mem[wr_ptr_q[PtrW-1:0]] <= i_pred_taken;
            tgt_mem[wr_ptr_q[PtrW-1:0]]   <= i_pred_target;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case (state_q)
            StRun: begin
                if (mispredict) begin
                    // Flush drops the queue and any wrong-path push of this cycle.
                    state_d  = StRecover;
                    rd_ptr_d = wr_ptr_q;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
            end
            StRecover: state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            upd_valid_q <= pop;
            redirect_q  <= mispredict;
            if (pop) begin
                upd_pc_q    <= e_pc;
                upd_taken_q <= i_res_taken;
            end
            if (mispredict) begin
                redirect_pc_q <= i_res_taken ? i_res_target : e_pc + N'(4);
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_upd_valid      = upd_valid_q;
    assign o_upd_pc         = upd_pc_q;
    assign o_upd_taken      = upd_taken_q;
    assign o_redirect       = redirect_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_inflight       = wr_ptr_q - rd_ptr_q;
    assign o_mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_bpu_resolve_ctrl.sv
// Scoreboard bench for bpu_resolve_ctrl: stimulus queues expected training/redirect
// records, a negedge monitor pops and compares them whenever o_upd_valid is seen.
module tb_bpu_resolve_ctrl;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_pred_valid = 1'b0;
    logic [N-1:0]      i_pred_pc = '0;
    logic              i_pred_taken = 1'b0;
    logic [N-1:0]      i_pred_target = '0;
    logic              o_pred_ready;
    logic              i_res_valid = 1'b0;
    logic              i_res_taken = 1'b0;
    logic [N-1:0]      i_res_target = '0;
    logic              o_upd_valid;
    logic [N-1:0]      o_upd_pc;
    logic              o_upd_taken;
    logic              o_redirect;
    logic [N-1:0]      o_redirect_pc;
    logic [2:0]        o_inflight;
    logic [CNT_W-1:0]  o_mispredict_cnt;

    bpu_resolve_ctrl #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_pred_valid     (i_pred_valid),
        .i_pred_pc        (i_pred_pc),
        .i_pred_taken     (i_pred_taken),
        .i_pred_target    (i_pred_target),
        .o_pred_ready     (o_pred_ready),
        .i_res_valid      (i_res_valid),
        .i_res_taken      (i_res_taken),
        .i_res_target     (i_res_target),
        .o_upd_valid      (o_upd_valid),
        .o_upd_pc         (o_upd_pc),
        .o_upd_taken      (o_upd_taken),
        .o_redirect       (o_redirect),
        .o_redirect_pc    (o_redirect_pc),
        .o_inflight       (o_inflight),
        .o_mispredict_cnt (o_mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every training pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_upd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("upd_pc", o_upd_pc, e.pc);
                    chk("upd_taken", 32'(o_upd_taken), 32'(e.taken));
                    chk("redirect", 32'(o_redirect), 32'(e.redir));
                    if (e.redir) chk("redirect_pc", o_redirect_pc, e.rpc);
                end
            end else if (o_redirect) begin
                chk("redirect_without_upd", 32'd1, 32'd0);
            end
        end
    end

    task automatic expect_upd(input logic [31:0] pc, input logic taken,
                              input logic redir, input logic [31:0] rpc);
        exp_t e;
        e.pc = pc; e.taken = taken; e.redir = redir; e.rpc = rpc;
        sb.push_back(e);
    endtask

    // One clock of stimulus; returns 1 time unit after the capturing edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                        input logic [31:0] ptg, input logic rv, input logic rt,
                        input logic [31:0] rtg);
        i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptg;
        i_res_valid = rv; i_res_taken = rt; i_res_target = rtg;
        @(posedge clk);
        #1;
        i_pred_valid = 1'b0;
        i_res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b1, pc, t, tg, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, tg);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(o_pred_ready), 32'd1);
        chk("rst_inflight", 32'(o_inflight), 32'd0);
        chk("rst_upd_valid", 32'(o_upd_valid), 32'd0);
        chk("rst_redirect", 32'(o_redirect), 32'd0);
        chk("rst_redirect_pc", o_redirect_pc, 32'd0);
        chk("rst_cnt", 32'(o_mispredict_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Fill to full, then a dropped fifth push
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 1'b0, 32'h0);
        chk("full_inflight", 32'(o_inflight), 32'd4);
        chk("full_ready", 32'(o_pred_ready), 32'd0);
        push(32'h20, 1'b0, 32'h0);
        chk("drop_inflight", 32'(o_inflight), 32'd4);
        for (int i = 0; i < 4; i++) begin
            expect_upd(32'h10 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            resolve(1'b0, 32'h0);
        end
        idle();
        chk("drain_inflight", 32'(o_inflight), 32'd0);

        // Correct resolve
        push(32'h10, 1'b0, 32'h0);
        expect_upd(32'h10, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        chk("correct_inflight", 32'(o_inflight), 32'd0);
        chk("correct_cnt", 32'(o_mispredict_cnt), 32'd0);
        idle();

        // Direction mispredict with a wrong-path push in the same cycle
        push(32'h10, 1'b0, 32'h0);
        push(32'h14, 1'b1, 32'h28);
        push(32'h18, 1'b0, 32'h0);
        expect_upd(32'h10, 1'b1, 1'b1, 32'h20);
        step(1'b1, 32'h1C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
        chk("flush_inflight", 32'(o_inflight), 32'd0);
        chk("recover_ready", 32'(o_pred_ready), 32'd0);
        chk("mp_cnt1", 32'(o_mispredict_cnt), 32'd1);
        idle();
        chk("run_ready", 32'(o_pred_ready), 32'd1);

        // Target mispredict, then not-taken mispredict
        push(32'h14, 1'b1, 32'h28);
        expect_upd(32'h14, 1'b1, 1'b1, 32'h30);
        resolve(1'b1, 32'h30);
        idle();
        push(32'h18, 1'b1, 32'h40);
        expect_upd(32'h18, 1'b0, 1'b1, 32'h1C);
        resolve(1'b0, 32'h0);
        chk("mp_cnt3", 32'(o_mispredict_cnt), 32'd3);
        idle();

        // Simultaneous push/pop across pointer wrap
        push(32'h40, 1'b0, 32'h0);
        push(32'h44, 1'b0, 32'h0);
        chk("pp_inflight0", 32'(o_inflight), 32'd2);
        for (int i = 0; i < 10; i++) begin
            expect_upd(32'h40 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            step(1'b1, 32'h48 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk("pp_inflight", 32'(o_inflight), 32'd2);
        end
        expect_upd(32'h68, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        expect_upd(32'h6C, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        idle();

        // Empty resolve: no pulses
        resolve(1'b1, 32'h99);
        chk("empty_upd", 32'(o_upd_valid), 32'd0);
        chk("empty_redirect", 32'(o_redirect), 32'd0);
        idle();

        // Reset during a redirect cycle (checked directly, not via the scoreboard)
        push(32'h10, 1'b0, 32'h0);
        resolve(1'b1, 32'h50);
        chk("pre_rst_redirect", 32'(o_redirect), 32'd1);
        chk("pre_rst_upd", 32'(o_upd_valid), 32'd1);
        chk("pre_rst_cnt", 32'(o_mispredict_cnt), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_redirect", 32'(o_redirect), 32'd0);
        chk("mid_rst_upd", 32'(o_upd_valid), 32'd0);
        chk("mid_rst_inflight", 32'(o_inflight), 32'd0);
        chk("mid_rst_cnt", 32'(o_mispredict_cnt), 32'd0);
        chk("mid_rst_ready", 32'(o_pred_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
